// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: a Moore FSM that sequences the datapath
// through fetch, decode, execute, memory and writeback, with memory-ready stalls.
module multi_cycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Inst_in,
  input  logic        zero,
  input  logic        overflow,
  input  logic        MIO_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        Jal,
  output logic        ALUSrc_A,
  output logic [1:0]  Branch,
  output logic [1:0]  DatatoReg,
  output logic [1:0]  ALUSrc_B,
  output logic [2:0]  ALU_Control,
  output logic [4:0]  state_out,
  output logic        illegal
);

  typedef enum logic [4:0] {
    S_IF      = 5'd0,
    S_ID      = 5'd1,
    S_MEM_ADR = 5'd2,
    S_MEM_RD  = 5'd3,
    S_LW_WB   = 5'd4,
    S_MEM_WR  = 5'd5,
    S_R_EXE   = 5'd6,
    S_R_WB    = 5'd7,
    S_BR_EXE  = 5'd8,
    S_J       = 5'd9,
    S_I_EXE   = 5'd10,
    S_I_WB    = 5'd11,
    S_JAL     = 5'd12,
    S_JR      = 5'd13,
    S_ERR     = 5'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_q, state_d;
  logic [5:0] opcode, funct;
  logic       unused_inst;

  assign opcode      = Inst_in[31:26];
  assign funct       = Inst_in[5:0];
  assign unused_inst = ^Inst_in[25:6];

  function automatic logic r_known(input logic [5:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SRL: r_known = 1'b1;
      default:                                                      r_known = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      FN_ADD:  r_alu = ALU_ADD;
      FN_SUB:  r_alu = ALU_SUB;
      FN_AND:  r_alu = ALU_AND;
      FN_OR:   r_alu = ALU_OR;
      FN_XOR:  r_alu = ALU_XOR;
      FN_NOR:  r_alu = ALU_NOR;
      FN_SLT:  r_alu = ALU_SLT;
      FN_SRL:  r_alu = ALU_SRL;
      default: r_alu = ALU_AND;
    endcase
  endfunction

  // lui is passed through the writeback mux, so its ALU op is irrelevant.
  function automatic logic [2:0] i_alu(input logic [5:0] op);
    case (op)
      OP_ADDI: i_alu = ALU_ADD;
      OP_SLTI: i_alu = ALU_SLT;
      OP_ANDI: i_alu = ALU_AND;
      OP_ORI:  i_alu = ALU_OR;
      OP_XORI: i_alu = ALU_XOR;
      default: i_alu = ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:      state_d = MIO_ready ? S_ID : S_IF;
      S_ID: begin
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEM_ADR;
          OP_RTYPE: begin
            if (funct == FN_JR)      state_d = S_JR;
            else if (r_known(funct)) state_d = S_R_EXE;
            else                     state_d = S_ERR;
          end
          OP_BEQ, OP_BNE: state_d = S_BR_EXE;
          OP_J:           state_d = S_J;
          OP_JAL:         state_d = S_JAL;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_d = S_I_EXE;
          default:        state_d = S_ERR;
        endcase
      end
      S_MEM_ADR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_d = MIO_ready ? S_LW_WB : S_MEM_RD;
      S_MEM_WR:  state_d = MIO_ready ? S_IF : S_MEM_WR;
      S_R_EXE:   state_d = S_R_WB;
      S_I_EXE:   state_d = S_I_WB;
      default:   state_d = S_IF;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    Jal         = 1'b0;
    ALUSrc_A    = 1'b0;
    Branch      = 2'b00;
    DatatoReg   = 2'b00;
    ALUSrc_B    = 2'b00;
    ALU_Control = ALU_AND;
    illegal     = 1'b0;
    state_out   = state_q;
    case (state_q)
      S_IF: begin
        MemRead     = 1'b1;
        ALUSrc_B    = 2'b01;
        ALU_Control = ALU_ADD;
        IRWrite     = MIO_ready;
        PCWrite     = MIO_ready;
      end
      // ALU computes PC + (imm<<2) while the opcode is still being decoded.
      S_ID: begin
        ALUSrc_B    = 2'b11;
        ALU_Control = ALU_ADD;
      end
      S_MEM_ADR: begin
        ALUSrc_A    = 1'b1;
        ALUSrc_B    = 2'b10;
        ALU_Control = ALU_ADD;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_LW_WB: begin
        RegWrite  = 1'b1;
        DatatoReg = 2'b01;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_R_EXE: begin
        ALUSrc_A    = 1'b1;
        ALU_Control = r_alu(funct);
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = !(((funct == FN_ADD) || (funct == FN_SUB)) && overflow);
      end
      S_BR_EXE: begin
        ALUSrc_A    = 1'b1;
        ALU_Control = ALU_SUB;
        Branch      = 2'b01;
        PCWriteCond = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
      end
      S_J: begin
        PCWrite = 1'b1;
        Branch  = 2'b10;
      end
      S_I_EXE: begin
        ALUSrc_A    = 1'b1;
        ALUSrc_B    = 2'b10;
        ALU_Control = i_alu(opcode);
      end
      S_I_WB: begin
        DatatoReg = (opcode == OP_LUI) ? 2'b10 : 2'b00;
        RegWrite  = !((opcode == OP_ADDI) && overflow);
      end
      S_JAL: begin
        PCWrite   = 1'b1;
        Branch    = 2'b10;
        Jal       = 1'b1;
        RegWrite  = 1'b1;
        DatatoReg = 2'b11;
      end
      S_JR: begin
        PCWrite = 1'b1;
        Branch  = 2'b11;
      end
      S_ERR:   illegal = 1'b1;
      default: ;
    endcase
    // Reset masks everything, including a state register not yet forced to IF.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      Jal         = 1'b0;
      ALUSrc_A    = 1'b0;
      Branch      = 2'b00;
      DatatoReg   = 2'b00;
      ALUSrc_B    = 2'b00;
      ALU_Control = ALU_AND;
      illegal     = 1'b0;
      state_out   = 5'd0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: a per-cycle vector table plus hand-written
// stall and reset sequences.
module tb_multi_cycle_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Inst_in;
  logic        zero, overflow, MIO_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, Jal, ALUSrc_A;
  logic [1:0]  Branch, DatatoReg, ALUSrc_B;
  logic [2:0]  ALU_Control;
  logic [4:0]  state_out;
  logic        illegal;

  multi_cycle_ctrl dut (
    .clk(clk), .rst(rst), .Inst_in(Inst_in), .zero(zero), .overflow(overflow), .MIO_ready(MIO_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .Jal(Jal), .ALUSrc_A(ALUSrc_A),
    .Branch(Branch), .DatatoReg(DatatoReg), .ALUSrc_B(ALUSrc_B), .ALU_Control(ALU_Control),
    .state_out(state_out), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic [19:0] act_o;
  assign act_o = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, Jal, ALUSrc_A,
                  Branch, DatatoReg, ALUSrc_B, ALU_Control, illegal};

  typedef struct {
    logic [31:0] inst;
    logic        rdy, z, ov;
    logic [4:0]  st;
    logic [19:0] o;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [19:0] pk(input logic pcw, pcwc, iord, mr, mw, irw, rw, rdst, jal, asa,
                                     input logic [1:0] br, d2r, asb, input logic [2:0] alu, input logic ill);
    pk = {pcw, pcwc, iord, mr, mw, irw, rw, rdst, jal, asa, br, d2r, asb, alu, ill};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] inst, input logic rdy, z, ov, input logic [4:0] st, input logic [19:0] o);
    vec_t v;
    v.inst = inst; v.rdy = rdy; v.z = z; v.ov = ov; v.st = st; v.o = o;
    tbl.push_back(v);
  endtask

  // Inputs change on the falling edge and are sampled 1 time unit later.
  task automatic step(input logic [31:0] inst, input logic r, rdy, z, ov);
    @(negedge clk);
    Inst_in = inst; rst = r; MIO_ready = rdy; zero = z; overflow = ov;
    #1;
  endtask

  localparam logic [31:0] I_ADD  = 32'h00221820, I_SUB  = 32'h00221822, I_SRL  = 32'h00221802;
  localparam logic [31:0] I_SLT  = 32'h0022182A, I_NOR  = 32'h00221827, I_ADDU = 32'h00221821;
  localparam logic [31:0] I_LW   = 32'h8C220004, I_SW   = 32'hAC220004;
  localparam logic [31:0] I_BEQ  = 32'h10220003, I_BNE  = 32'h14220003;
  localparam logic [31:0] I_J    = 32'h08000010, I_JAL  = 32'h0C000010, I_JR  = 32'h03E00008;
  localparam logic [31:0] I_ADDI = 32'h20220005, I_SLTI = 32'h2822FFFF, I_ORI = 32'h34220001;
  localparam logic [31:0] I_LUI  = 32'h3C011234, I_BAD  = 32'hFC000000;

  logic [19:0] O_IF, O_IFS, O_ID, O_ADR, O_ERR, O_NONE;

  initial begin
    int n;
    O_IF   = pk(H,L,L,H,L,H,L,L,L,L, 2'b00,2'b00,2'b01,3'b010, L);
    O_IFS  = pk(L,L,L,H,L,L,L,L,L,L, 2'b00,2'b00,2'b01,3'b010, L);
    O_ID   = pk(L,L,L,L,L,L,L,L,L,L, 2'b00,2'b00,2'b11,3'b010, L);
    O_ADR  = pk(L,L,L,L,L,L,L,L,L,H, 2'b00,2'b00,2'b10,3'b010, L);
    O_ERR  = pk(L,L,L,L,L,L,L,L,L,L, 2'b00,2'b00,2'b00,3'b000, H);
    O_NONE = '0;

    // add, then add with overflow at writeback
    add(I_ADD,H,L,L,5'd0,O_IF); add(I_ADD,H,L,L,5'd1,O_ID);
    add(I_ADD,H,L,L,5'd6,pk(L,L,L,L,L,L,L,L,L,H,2'b00,2'b00,2'b00,3'b010,L));
    add(I_ADD,H,L,L,5'd7,pk(L,L,L,L,L,L,H,H,L,L,2'b00,2'b00,2'b00,3'b000,L));
    add(I_ADD,H,L,H,5'd0,O_IF); add(I_ADD,H,L,H,5'd1,O_ID);
    add(I_ADD,H,L,H,5'd6,pk(L,L,L,L,L,L,L,L,L,H,2'b00,2'b00,2'b00,3'b010,L));
    add(I_ADD,H,L,H,5'd7,pk(L,L,L,L,L,L,L,H,L,L,2'b00,2'b00,2'b00,3'b000,L));
    // sub suppresses on overflow; srl ignores overflow
    add(I_SUB,H,L,H,5'd0,O_IF); add(I_SUB,H,L,H,5'd1,O_ID);
    add(I_SUB,H,L,H,5'd6,pk(L,L,L,L,L,L,L,L,L,H,2'b00,2'b00,2'b00,3'b110,L));
    add(I_SUB,H,L,H,5'd7,pk(L,L,L,L,L,L,L,H,L,L,2'b00,2'b00,2'b00,3'b000,L));
    add(I_SRL,H,L,H,5'd0,O_IF); add(I_SRL,H,L,H,5'd1,O_ID);
    add(I_SRL,H,L,H,5'd6,pk(L,L,L,L,L,L,L,L,L,H,2'b00,2'b00,2'b00,3'b101,L));
    add(I_SRL,H,L,H,5'd7,pk(L,L,L,L,L,L,H,H,L,L,2'b00,2'b00,2'b00,3'b000,L));
    add(I_SLT,H,L,L,5'd0,O_IF); add(I_SLT,H,L,L,5'd1,O_ID);
    add(I_SLT,H,L,L,5'd6,pk(L,L,L,L,L,L,L,L,L,H,2'b00,2'b00,2'b00,3'b111,L));
    add(I_SLT,H,L,L,5'd7,pk(L,L,L,L,L,L,H,H,L,L,2'b00,2'b00,2'b00,3'b000,L));
    add(I_NOR,H,L,L,5'd0,O_IF); add(I_NOR,H,L,L,5'd1,O_ID);
    add(I_NOR,H,L,L,5'd6,pk(L,L,L,L,L,L,L,L,L,H,2'b00,2'b00,2'b00,3'b100,L));
    add(I_NOR,H,L,L,5'd7,pk(L,L,L,L,L,L,H,H,L,L,2'b00,2'b00,2'b00,3'b000,L));
    // lw and sw without stalls
    add(I_LW,H,L,L,5'd0,O_IF); add(I_LW,H,L,L,5'd1,O_ID); add(I_LW,H,L,L,5'd2,O_ADR);
    add(I_LW,H,L,L,5'd3,pk(L,L,H,H,L,L,L,L,L,L,2'b00,2'b00,2'b00,3'b000,L));
    add(I_LW,H,L,L,5'd4,pk(L,L,L,L,L,L,H,L,L,L,2'b00,2'b01,2'b00,3'b000,L));
    add(I_SW,H,L,L,5'd0,O_IF); add(I_SW,H,L,L,5'd1,O_ID); add(I_SW,H,L,L,5'd2,O_ADR);
    add(I_SW,H,L,L,5'd5,pk(L,L,H,L,H,L,L,L,L,L,2'b00,2'b00,2'b00,3'b000,L));
    // branches across zero
    add(I_BEQ,H,H,L,5'd0,O_IF); add(I_BEQ,H,H,L,5'd1,O_ID);
    add(I_BEQ,H,H,L,5'd8,pk(L,H,L,L,L,L,L,L,L,H,2'b01,2'b00,2'b00,3'b110,L));
    add(I_BEQ,H,L,L,5'd0,O_IF); add(I_BEQ,H,L,L,5'd1,O_ID);
    add(I_BEQ,H,L,L,5'd8,pk(L,L,L,L,L,L,L,L,L,H,2'b01,2'b00,2'b00,3'b110,L));
    add(I_BNE,H,H,L,5'd0,O_IF); add(I_BNE,H,H,L,5'd1,O_ID);
    add(I_BNE,H,H,L,5'd8,pk(L,L,L,L,L,L,L,L,L,H,2'b01,2'b00,2'b00,3'b110,L));
    add(I_BNE,H,L,L,5'd0,O_IF); add(I_BNE,H,L,L,5'd1,O_ID);
    add(I_BNE,H,L,L,5'd8,pk(L,H,L,L,L,L,L,L,L,H,2'b01,2'b00,2'b00,3'b110,L));
    // j preceded by one fetch stall, then jal, jr
    add(I_J,L,L,L,5'd0,O_IFS); add(I_J,H,L,L,5'd0,O_IF); add(I_J,H,L,L,5'd1,O_ID);
    add(I_J,H,L,L,5'd9,pk(H,L,L,L,L,L,L,L,L,L,2'b10,2'b00,2'b00,3'b000,L));
    add(I_JAL,H,L,L,5'd0,O_IF); add(I_JAL,H,L,L,5'd1,O_ID);
    add(I_JAL,H,L,L,5'd12,pk(H,L,L,L,L,L,H,L,H,L,2'b10,2'b11,2'b00,3'b000,L));
    add(I_JR,H,L,L,5'd0,O_IF); add(I_JR,H,L,L,5'd1,O_ID);
    add(I_JR,H,L,L,5'd13,pk(H,L,L,L,L,L,L,L,L,L,2'b11,2'b00,2'b00,3'b000,L));
    // I-type
    add(I_ADDI,H,L,L,5'd0,O_IF); add(I_ADDI,H,L,L,5'd1,O_ID);
    add(I_ADDI,H,L,L,5'd10,pk(L,L,L,L,L,L,L,L,L,H,2'b00,2'b00,2'b10,3'b010,L));
    add(I_ADDI,H,L,L,5'd11,pk(L,L,L,L,L,L,H,L,L,L,2'b00,2'b00,2'b00,3'b000,L));
    add(I_ADDI,H,L,H,5'd0,O_IF); add(I_ADDI,H,L,H,5'd1,O_ID);
    add(I_ADDI,H,L,H,5'd10,pk(L,L,L,L,L,L,L,L,L,H,2'b00,2'b00,2'b10,3'b010,L));
    add(I_ADDI,H,L,H,5'd11,O_NONE);
    add(I_SLTI,H,L,L,5'd0,O_IF); add(I_SLTI,H,L,L,5'd1,O_ID);
    add(I_SLTI,H,L,L,5'd10,pk(L,L,L,L,L,L,L,L,L,H,2'b00,2'b00,2'b10,3'b111,L));
    add(I_SLTI,H,L,L,5'd11,pk(L,L,L,L,L,L,H,L,L,L,2'b00,2'b00,2'b00,3'b000,L));
    add(I_ORI,H,L,H,5'd0,O_IF); add(I_ORI,H,L,H,5'd1,O_ID);
    add(I_ORI,H,L,H,5'd10,pk(L,L,L,L,L,L,L,L,L,H,2'b00,2'b00,2'b10,3'b001,L));
    add(I_ORI,H,L,H,5'd11,pk(L,L,L,L,L,L,H,L,L,L,2'b00,2'b00,2'b00,3'b000,L));
    // illegal opcode and unmapped funct
    add(I_BAD,H,L,L,5'd0,O_IF); add(I_BAD,H,L,L,5'd1,O_ID); add(I_BAD,H,L,L,5'd14,O_ERR);
    add(I_ADDU,H,L,L,5'd0,O_IF); add(I_ADDU,H,L,L,5'd1,O_ID); add(I_ADDU,H,L,L,5'd14,O_ERR);

    // reset: two cycles with memory ready, everything masked
    Inst_in = '0; rst = 1'b1; MIO_ready = 1'b1; zero = 1'b0; overflow = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(32'h0, H, H, L, L);
      chk($sformatf("rst%0d_state", i), 32'(state_out), 32'd0);
      chk($sformatf("rst%0d_outs", i), 32'(act_o), 32'(O_NONE));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].inst, L, tbl[i].rdy, tbl[i].z, tbl[i].ov);
      chk($sformatf("vec%0d_state", i), 32'(state_out), 32'(tbl[i].st));
      chk($sformatf("vec%0d_outs", i), 32'(act_o), 32'(tbl[i].o));
    end

    // lw with three not-ready cycles in MEM_RD: 8 cycles IF..LW_WB
    n = 0;
    step(I_LW, L, H, L, L); n++; chk("lws_if", 32'(state_out), 32'd0);
    step(I_LW, L, H, L, L); n++; chk("lws_id", 32'(state_out), 32'd1);
    step(I_LW, L, H, L, L); n++; chk("lws_adr", 32'(state_out), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(I_LW, L, L, L, L); n++;
      chk($sformatf("lws_hold%0d", i), 32'(state_out), 32'd3);
      chk($sformatf("lws_hold%0d_rw", i), 32'(RegWrite), 32'd0);
      chk($sformatf("lws_hold%0d_mr", i), 32'(MemRead), 32'd1);
    end
    step(I_LW, L, H, L, L); n++; chk("lws_rd_done", 32'(state_out), 32'd3);
    step(I_LW, L, H, L, L); n++;
    chk("lws_wb", 32'(state_out), 32'd4);
    chk("lws_wb_d2r", 32'(DatatoReg), 32'd1);
    chk("lws_wb_rw", 32'(RegWrite), 32'd1);
    chk("lws_cycles", 32'(n), 32'd8);

    // lui selects the immediate on writeback
    step(I_LUI, L, H, L, H); chk("lui_if", 32'(state_out), 32'd0);
    step(I_LUI, L, H, L, H); chk("lui_id", 32'(state_out), 32'd1);
    step(I_LUI, L, H, L, H); chk("lui_exe", 32'(state_out), 32'd10);
    step(I_LUI, L, H, L, H);
    chk("lui_wb", 32'(state_out), 32'd11);
    chk("lui_wb_d2r", 32'(DatatoReg), 32'd2);
    chk("lui_wb_rw", 32'(RegWrite), 32'd1);

    // reset while sw stalls in MEM_WR
    step(I_SW, L, H, L, L); chk("swr_if", 32'(state_out), 32'd0);
    step(I_SW, L, H, L, L); chk("swr_id", 32'(state_out), 32'd1);
    step(I_SW, L, H, L, L); chk("swr_adr", 32'(state_out), 32'd2);
    step(I_SW, L, L, L, L);
    chk("swr_wr", 32'(state_out), 32'd5);
    chk("swr_wr_mw", 32'(MemWrite), 32'd1);
    step(I_SW, L, L, L, L); chk("swr_stall", 32'(state_out), 32'd5);
    step(I_SW, H, L, L, L);
    chk("swr_rst_state", 32'(state_out), 32'd0);
    chk("swr_rst_outs", 32'(act_o), 32'(O_NONE));
    step(I_SW, L, L, L, L);
    chk("swr_after_state", 32'(state_out), 32'd0);
    chk("swr_after_outs", 32'(act_o), 32'(O_IFS));
    step(I_SW, L, H, L, L); chk("swr_fetch_outs", 32'(act_o), 32'(O_IF));
    step(I_SW, L, H, L, L); chk("swr_fetch_id", 32'(state_out), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 Inst_in  input  32  instruction register contents; valid from ID onward.
REQ-004 zero, overflow  input  1 each  ALU flags from the datapath.
REQ-005 MIO_ready  input  1  memory handshake; high = current access completes this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, Jal, ALUSrc_A  output  1 each  datapath strobes/selects.
REQ-007 Branch  output  2  PC source: 00 ALU (PC+4), 01 branch target, 10 jump target, 11 register rs.
REQ-008 DatatoReg  output  2  writeback source: 00 ALU, 01 memory, 10 lui immediate, 11 PC (link).
REQ-009 ALUSrc_B  output  2  00 reg B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
REQ-010 ALU_Control  output  3  000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 slt.
REQ-011 state_out  output  5  current state code, for debug.
REQ-012 illegal  output  1  high for the one cycle spent in ERR.

Function
REQ-013 Moore FSM; all outputs SHALL be decoded combinationally from the registered state (plus opcode/funct, zero, overflow where stated); unlisted outputs 0.
REQ-014 States/codes: IF 0, ID 1, MEM_ADR 2, MEM_RD 3, LW_WB 4, MEM_WR 5, R_EXE 6, R_WB 7, BR_EXE 8, J 9, I_EXE 10, I_WB 11, JAL 12, JR 13, ERR 14.
REQ-015 IF: MemRead=1, IorD=0, ALUSrc_A=0, ALUSrc_B=01, ALU_Control=010, Branch=00; IRWrite=PCWrite=MIO_ready; stay while MIO_ready=0, else go to ID.
REQ-016 ID: ALUSrc_A=0, ALUSrc_B=11, ALU_Control=010 (branch target precompute); next state by opcode: 0x23/0x2B->MEM_ADR; 0x00 (funct 0x08)->JR; other R-type->R_EXE; 0x04/0x05->BR_EXE; 0x02->J; 0x03->JAL; 0x08,0x0A,0x0C,0x0D,0x0E,0x0F->I_EXE; anything else->ERR.
REQ-017 R-type funct mapping: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt, 0x02 srl; unmapped funct->ERR from ID.
REQ-018 MEM_ADR: ALUSrc_A=1, ALUSrc_B=10, add; lw->MEM_RD, sw->MEM_WR.
REQ-019 MEM_RD: MemRead=1, IorD=1; hold until MIO_ready=1, then LW_WB. MEM_WR: MemWrite=1, IorD=1; hold until MIO_ready=1, then IF.
REQ-020 LW_WB: RegWrite=1, RegDst=0, DatatoReg=01; ->IF.
REQ-021 R_EXE: ALUSrc_A=1, ALUSrc_B=00, ALU_Control per funct; ->R_WB. R_WB: RegDst=1, DatatoReg=00, RegWrite=1 except add/sub with overflow=1 (RegWrite=0); ->IF.
REQ-022 BR_EXE: ALUSrc_A=1, ALUSrc_B=00, sub, Branch=01, PCWriteCond=1 when (beq & zero) or (bne & !zero); ->IF.
REQ-023 I_EXE: ALUSrc_A=1, ALUSrc_B=10; addi add, slti slt, andi and, ori or, xori xor, lui don't-care; ->I_WB. I_WB: RegDst=0, DatatoReg=10 for lui else 00, RegWrite=1 except addi with overflow=1; ->IF.
REQ-024 J: PCWrite=1, Branch=10; ->IF. JAL: PCWrite=1, Branch=10, Jal=1, RegWrite=1, DatatoReg=11; ->IF. JR: PCWrite=1, Branch=11; ->IF.
REQ-025 ERR: illegal=1, no write strobes; ->IF after exactly one cycle.
REQ-026 Latency with MIO_ready=1: R/I-type 4 cycles, lw 5, sw 4, branch 3, j/jal/jr 3; each MIO_ready=0 cycle in IF/MEM_RD/MEM_WR adds one cycle.

Reset
REQ-027 rst=1 at a clock edge SHALL force state IF regardless of current state, including mid-stall.
REQ-028 While rst=1, PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite SHALL be 0 and illegal 0; state_out=0.
REQ-029 After rst deasserts, the first cycle is a normal IF fetch.

Verification
REQ-030 rst high 2 cycles, MIO_ready=1 -> state_out=0, all strobes 0; next cycle MemRead=1, IRWrite=1, PCWrite=1, ALU_Control=010.
REQ-031 Inst_in=0x00221820 (add), MIO_ready=1 -> states 0,1,6,7,0; state 7: RegWrite=1, RegDst=1, DatatoReg=00; with overflow=1 in state 7 -> RegWrite=0.
REQ-032 Inst_in=0x8C220004 (lw), MIO_ready=0 for 3 cycles in MEM_RD -> state_out stays 3 for 3 cycles, RegWrite=0; then 4 with DatatoReg=01, RegWrite=1; total 8 cycles.
REQ-033 beq (0x10220003) zero=1 -> state 8 PCWriteCond=1, Branch=01, ALU_Control=110; bne (0x14220003) zero=1 -> PCWriteCond=0.
REQ-034 Inst_in=0xFC000000 -> states 0,1,14,0; illegal=1 only in 14; no write strobes.
REQ-035 jal (0x0C000010) -> state 12: PCWrite=1, Jal=1, RegWrite=1, DatatoReg=11, Branch=10; rst asserted during MEM_WR stall -> next state 0, MemWrite=0.
